axi_lite_arbiter: RTL and testbench
===================================

# axi_lite_arbiter

N-master to 1-slave AXI4-Lite arbiter. It merges the IFU and LSU request ports onto the single upstream port of the address-decoding crossbar, so both masters share one memory/peripheral fabric. It grants one whole transaction at a time, either one read or one write, using round-robin order. The grant is held until that transaction's response handshake completes.

## Interface
- NUM_MASTERS, default 2: number of upstream masters, at least 1. IDX_W = max(1, $clog2(NUM_MASTERS)).
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- m  axi_lite_if.slave  [NUM_MASTERS]  master-side ports. Index 0 is the IFU; index 1 is the LSU.
- s  axi_lite_if.master  1  downstream port to the crossbar.
- Interface signals: araddr[31:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready, awaddr[31:0], awvalid, awready, wdata[31:0], wmask[3:0], wvalid, wready, bresp[1:0], bvalid, bready.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registers: state, gnt_idx[IDX_W-1:0], rr_ptr[IDX_W-1:0], aw_done, w_done.
- Request of master i: req[i] = m[i].arvalid | m[i].awvalid.
  - If a master has both asserted, the read is taken first.
  - wvalid alone is not a request.
- IDLE:
  - The winner is the first i with req[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - At the clock edge, gnt_idx <= winner. Next state is RD_ADDR if m[winner].arvalid, else WR_REQ. aw_done and w_done are cleared.
  - With no request, state stays IDLE.
- RD_ADDR:
  - s.arvalid = m[gnt].arvalid; s.araddr = m[gnt].araddr; m[gnt].arready = s.arready.
  - On s.arvalid & s.arready, go to RD_DATA.
- RD_DATA:
  - s.rready = m[gnt].rready; m[gnt].rvalid = s.rvalid.
  - On s.rvalid & s.rready, go to IDLE and set rr_ptr <= gnt_idx+1 (wraps to 0 at NUM_MASTERS).
- WR_REQ:
  - AW and W are forwarded from m[gnt] independently. Each channel is masked once its done flag is set: s.awvalid = m[gnt].awvalid & ~aw_done, and likewise for W.
  - aw_done is set on the AW handshake; w_done is set on the W handshake.
  - Go to WR_RESP in the cycle both handshakes have completed. This includes both completing in the same cycle, or one completing while the other's flag is already set.
- WR_RESP:
  - s.bready = m[gnt].bready; m[gnt].bvalid = s.bvalid.
  - On the B handshake, go to IDLE and set rr_ptr <= gnt_idx+1 modulo N.
- Non-granted masters, and all masters in IDLE: arready, awready, wready, rvalid and bvalid are 0.
- rdata, rresp and bresp are broadcast to all masters; the valid signals qualify them.
- s-side valid and ready signals are 0 in any state that does not forward them. s address, data and mask outputs follow m[gnt_idx].
- Protocol violation: a master dropping valid before its handshake does not release the grant. The arbiter waits.

## Timing
- Reset: state=IDLE, gnt_idx=0, rr_ptr=0, aw_done=w_done=0. Every valid/ready output is 0 from the cycle after reset is sampled.
- Reset during any state aborts the transaction without a response to the master. The crossbar is reset by the same signal.
- Grant is registered, costing one bubble cycle.
  - Request seen in IDLE at cycle t: s.arvalid/awvalid is asserted at t+1.
  - Minimum read with a zero-wait slave: AR at t+1, R at t+2, IDLE at t+3, next grant decision at t+3, forwarded at t+4.
  - Minimum write: AW and W at t+1, B at t+2, IDLE at t+3.
- No combinational path from s ready to m valid, or the reverse, other than the direct per-channel pass-through.
- NUM_MASTERS=1: the block behaves as a pass-through with the single IDLE bubble per transaction.

## Test plan
- Single read: m[0] araddr=0x80000000 with slave rdata=0x12345678. m[0].rdata=0x12345678 and rresp=0. m[1] sees no rvalid. The bus is in IDLE 3 cycles after the request.
- Simultaneous reads from m[0] and m[1] after reset: m[0] is served first, then m[1]. A repeat of both requests serves m[1]'s… round-robin: rr_ptr=0 gives m[0], and rr_ptr then becomes 1. Three back-to-back contention rounds give the order 0,1,0,1,0,1.
- Write with W before AW: m[1] asserts wvalid with wdata=0xDEADBEEF and wmask=0xF two cycles before awvalid with awaddr=0xa00003f8. One AW and one W are issued downstream. B is routed to m[1] only. No wready reaches m[1] before the grant.
- Staggered slave readiness: awready is held at 0 for 3 cycles while wready=1. w_done is set first. WR_RESP is entered only after the AW handshake. Exactly one W beat is seen downstream.
- Mixed traffic: m[0] issues a read while m[1] issues a write in the same cycle. Read-then-write ordering holds, and each response is delivered only to its owner.
- Reset asserted in RD_DATA with s.rvalid=0: all outputs are 0 the next cycle, state is IDLE, and a new request from m[1] is granted after the reset is released.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Round-robin AXI4-Lite arbiter: merges NUM_MASTERS request ports onto one downstream port,
// granting one whole read or write transaction at a time until its response handshake.
module axi_lite_arbiter #(
   parameter int NUM_MASTERS = 2,
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   // master-side ports, index 0 = IFU, index 1 = LSU
   input  logic [NUM_MASTERS-1:0][31:0]      m_araddr_i,
   input  logic [NUM_MASTERS-1:0]            m_arvalid_i,
   output logic [NUM_MASTERS-1:0]            m_arready_o,
   output logic [NUM_MASTERS-1:0][31:0]      m_rdata_o,
   output logic [NUM_MASTERS-1:0][1:0]       m_rresp_o,
   output logic [NUM_MASTERS-1:0]            m_rvalid_o,
   input  logic [NUM_MASTERS-1:0]            m_rready_i,
   input  logic [NUM_MASTERS-1:0][31:0]      m_awaddr_i,
   input  logic [NUM_MASTERS-1:0]            m_awvalid_i,
   output logic [NUM_MASTERS-1:0]            m_awready_o,
   input  logic [NUM_MASTERS-1:0][31:0]      m_wdata_i,
   input  logic [NUM_MASTERS-1:0][3:0]       m_wmask_i,
   input  logic [NUM_MASTERS-1:0]            m_wvalid_i,
   output logic [NUM_MASTERS-1:0]            m_wready_o,
   output logic [NUM_MASTERS-1:0][1:0]       m_bresp_o,
   output logic [NUM_MASTERS-1:0]            m_bvalid_o,
   input  logic [NUM_MASTERS-1:0]            m_bready_i,
   // downstream port to the crossbar
   output logic [31:0]                       s_araddr_o,
   output logic                              s_arvalid_o,
   input  logic                              s_arready_i,
   input  logic [31:0]                       s_rdata_i,
   input  logic [1:0]                        s_rresp_i,
   input  logic                              s_rvalid_i,
   output logic                              s_rready_o,
   output logic [31:0]                       s_awaddr_o,
   output logic                              s_awvalid_o,
   input  logic                              s_awready_i,
   output logic [31:0]                       s_wdata_o,
   output logic [3:0]                        s_wmask_o,
   output logic                              s_wvalid_o,
   input  logic                              s_wready_i,
   input  logic [1:0]                        s_bresp_i,
   input  logic                              s_bvalid_i,
   output logic                              s_bready_o,
   // debug view: state encoding IDLE=0 RD_ADDR=1 RD_DATA=2 WR_REQ=3 WR_RESP=4
   output logic [2:0]                        state_o,
   output logic [IDX_W-1:0]                  gnt_idx_o,
   output logic [IDX_W-1:0]                  rr_ptr_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } state_e;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                     aw_done_q, aw_done_d;
   logic                     w_done_q, w_done_d;
   logic [NUM_MASTERS-1:0]   req;
   logic [IDX_W-1:0]         win_idx, cand, rr_next;
   logic                     win_found;
   logic                     aw_hs, w_hs;

   assign req = m_arvalid_i | m_awvalid_i;

   // Scan from the farthest offset down so the candidate closest to rr_ptr is written last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_ptr_q;
      cand      = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign rr_next = (gnt_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

   // Every channel is a plain valid/ready pair: a beat transfers in the cycle both are high;
   // valid never waits on ready, and only the granted master's channel is connected through.
   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      rr_ptr_d    = rr_ptr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      m_arready_o = '0;
      m_rvalid_o  = '0;
      m_awready_o = '0;
      m_wready_o  = '0;
      m_bvalid_o  = '0;
      s_arvalid_o = 1'b0;
      s_rready_o  = 1'b0;
      s_awvalid_o = 1'b0;
      s_wvalid_o  = 1'b0;
      s_bready_o  = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (win_found) begin
               gnt_idx_d = win_idx;
               state_d   = m_arvalid_i[win_idx] ? RD_ADDR : WR_REQ;
            end
         end
         RD_ADDR: begin
            s_arvalid_o            = m_arvalid_i[gnt_idx_q];
            m_arready_o[gnt_idx_q] = s_arready_i;
            if (s_arvalid_o && s_arready_i) state_d = RD_DATA;
         end
         RD_DATA: begin
            s_rready_o            = m_rready_i[gnt_idx_q];
            m_rvalid_o[gnt_idx_q] = s_rvalid_i;
            if (s_rvalid_i && s_rready_o) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next;
            end
         end
         WR_REQ: begin
            // A channel that already handshook is masked so it cannot transfer a second beat.
            s_awvalid_o            = m_awvalid_i[gnt_idx_q] & ~aw_done_q;
            m_awready_o[gnt_idx_q] = s_awready_i & ~aw_done_q;
            s_wvalid_o             = m_wvalid_i[gnt_idx_q] & ~w_done_q;
            m_wready_o[gnt_idx_q]  = s_wready_i & ~w_done_q;
            aw_hs                  = s_awvalid_o & s_awready_i;
            w_hs                   = s_wvalid_o & s_wready_i;
            aw_done_d              = aw_done_q | aw_hs;
            w_done_d               = w_done_q | w_hs;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            s_bready_o            = m_bready_i[gnt_idx_q];
            m_bvalid_o[gnt_idx_q] = s_bvalid_i;
            if (s_bvalid_i && s_bready_o) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign s_araddr_o = m_araddr_i[gnt_idx_q];
   assign s_awaddr_o = m_awaddr_i[gnt_idx_q];
   assign s_wdata_o  = m_wdata_i[gnt_idx_q];
   assign s_wmask_o  = m_wmask_i[gnt_idx_q];
   assign m_rdata_o  = {NUM_MASTERS{s_rdata_i}};
   assign m_rresp_o  = {NUM_MASTERS{s_rresp_i}};
   assign m_bresp_o  = {NUM_MASTERS{s_bresp_i}};

   assign state_o   = state_q;
   assign gnt_idx_o = gnt_idx_q;
   assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: behavioural masters and slave, a transaction-level arbitration
// model and address/data scoreboards, with directed scenarios followed by a random phase.
module tb_axi_lite_arbiter;
   localparam int N = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [N-1:0][31:0] m_araddr_i, m_awaddr_i, m_wdata_i, m_rdata_o;
   logic [N-1:0][3:0]  m_wmask_i;
   logic [N-1:0][1:0]  m_rresp_o, m_bresp_o;
   logic [N-1:0]       m_arvalid_i, m_arready_o, m_rvalid_o, m_rready_i;
   logic [N-1:0]       m_awvalid_i, m_awready_o, m_wvalid_i, m_wready_o;
   logic [N-1:0]       m_bvalid_o, m_bready_i;
   logic [31:0]        s_araddr_o, s_rdata_i, s_awaddr_o, s_wdata_o;
   logic [3:0]         s_wmask_o;
   logic [1:0]         s_rresp_i, s_bresp_i;
   logic               s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o;
   logic               s_awvalid_o, s_awready_i, s_wvalid_o, s_wready_i;
   logic               s_bvalid_i, s_bready_o;
   logic [2:0]         state_o;
   logic [0:0]         gnt_idx_o, rr_ptr_o;

   axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
      .clk(clk), .reset(reset),
      .m_araddr_i(m_araddr_i), .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
      .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
      .m_awaddr_i(m_awaddr_i), .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
      .m_wdata_i(m_wdata_i), .m_wmask_i(m_wmask_i), .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
      .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i),
      .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
      .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
      .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
      .s_wdata_o(s_wdata_o), .s_wmask_o(s_wmask_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
      .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
      .state_o(state_o), .gnt_idx_o(gnt_idx_o), .rr_ptr_o(rr_ptr_o)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural masters ----------------
   bit          act[N], m_wr[N], ar_ok[N], aw_ok[N], w_ok[N];
   logic [31:0] m_addr[N], m_data[N];
   logic [3:0]  m_mask[N];
   int          lead[N], started[N], finished[N], start_cyc[N], resp_cyc[N];
   bit          rand_mode;

   task automatic start_txn(input int i, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] mk, input int ld);
      act[i] = 1; m_wr[i] = wr; ar_ok[i] = 0; aw_ok[i] = 0; w_ok[i] = 0;
      m_addr[i] = a; m_data[i] = d; m_mask[i] = mk; lead[i] = ld;
      started[i]++; start_cyc[i] = cyc + 1;
   endtask

   // ---------------- behavioural slave ----------------
   bit          sl_r_pend, sl_aw_got, sl_w_got, sl_b_pend, sl_r_block;
   logic [31:0] sl_raddr, sl_waddr;
   int          sl_r_wait, sl_b_wait, aw_stall;
   int          s_ar_n, s_aw_n, s_w_n, w_hs_cyc, aw_hs_cyc;

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h1234_5678 : (a ^ 32'hA5A5_0F0F);
   endfunction
   function automatic logic [1:0] rd_resp(input logic [31:0] a);
      return a[3:2];
   endfunction
   function automatic logic [1:0] wr_resp(input logic [31:0] a);
      return a[5:4];
   endfunction

   // ---------------- scoreboard and arbitration model ----------------
   logic [31:0] exp_ar_q[$];
   logic [31:0] exp_aw_q[$];
   logic [35:0] exp_w_q[$];
   int          obs_rsp_q[$];
   bit          mdl_idle, mdl_rd, fresh;
   int          mdl_rr, mdl_own;

   function automatic bit rnd_bit();
      return rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         m_arvalid_i[i] = act[i] && !m_wr[i] && !ar_ok[i];
         m_awvalid_i[i] = act[i] && m_wr[i] && !aw_ok[i] && (lead[i] == 0);
         m_wvalid_i[i]  = act[i] && m_wr[i] && !w_ok[i];
         m_araddr_i[i]  = m_addr[i];
         m_awaddr_i[i]  = m_addr[i];
         m_wdata_i[i]   = m_data[i];
         m_wmask_i[i]   = m_mask[i];
         m_rready_i[i]  = rnd_bit();
         m_bready_i[i]  = rnd_bit();
      end
      s_arready_i = rnd_bit();
      s_awready_i = (aw_stall == 0) && rnd_bit();
      s_wready_i  = rnd_bit();
      s_rvalid_i  = sl_r_pend && (sl_r_wait == 0) && !sl_r_block;
      s_rdata_i   = s_rvalid_i ? rd_val(sl_raddr) : $urandom;
      s_rresp_i   = s_rvalid_i ? rd_resp(sl_raddr) : 2'(s_rdata_i[1:0]);
      s_bvalid_i  = sl_b_pend && (sl_b_wait == 0);
      s_bresp_i   = s_bvalid_i ? wr_resp(sl_waddr) : 2'($urandom_range(0, 3));
   endtask

   task automatic sample_update();
      bit found;
      int j;
      if (mdl_idle) begin
         chk("idle_quiet", {m_arready_o, m_awready_o, m_wready_o, m_rvalid_o, m_bvalid_o,
                            s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o}, 64'd0);
         found = 0;
         for (int k = 0; k < N; k++) begin
            j = (mdl_rr + k) % N;
            if (!found && (m_arvalid_i[j] || m_awvalid_i[j])) begin
               found = 1; mdl_own = j; mdl_rd = m_arvalid_i[j];
            end
         end
         if (found) begin
            mdl_idle = 0; fresh = 1;
            if (mdl_rd) exp_ar_q.push_back(m_addr[mdl_own]);
            else begin
               exp_aw_q.push_back(m_addr[mdl_own]);
               exp_w_q.push_back({m_mask[mdl_own], m_data[mdl_own]});
            end
         end
      end else begin
         if (fresh) chk("grant_latency", mdl_rd ? s_arvalid_o : s_awvalid_o, 64'd1);
         fresh = 0;
         for (int i = 0; i < N; i++)
            if (i != mdl_own)
               chk("non_owner_quiet", {m_arready_o[i], m_awready_o[i], m_wready_o[i],
                                       m_rvalid_o[i], m_bvalid_o[i]}, 64'd0);
      end
      if (sl_r_pend) chk("ar_single_beat", s_arvalid_o, 64'd0);
      if (sl_aw_got) chk("aw_masked", s_awvalid_o, 64'd0);
      if (sl_w_got)  chk("w_masked", s_wvalid_o, 64'd0);
      if (s_bready_o) chk("b_after_aw_w", sl_aw_got && sl_w_got, 64'd1);
      if (s_rready_o) chk("r_after_ar", sl_r_pend, 64'd1);

      if (sl_r_pend && sl_r_wait > 0) sl_r_wait--;
      if (sl_b_pend && sl_b_wait > 0) sl_b_wait--;
      if (s_awvalid_o && aw_stall > 0) aw_stall--;

      if (s_arvalid_o && s_arready_i) begin
         s_ar_n++;
         chk("ar_expected", exp_ar_q.size() > 0, 64'd1);
         if (exp_ar_q.size() > 0) chk("araddr", s_araddr_o, exp_ar_q.pop_front());
         sl_r_pend = 1; sl_raddr = s_araddr_o; sl_r_wait = rand_mode ? $urandom_range(0, 2) : 0;
      end
      if (s_awvalid_o && s_awready_i) begin
         s_aw_n++; aw_hs_cyc = cyc;
         chk("aw_expected", exp_aw_q.size() > 0, 64'd1);
         if (exp_aw_q.size() > 0) chk("awaddr", s_awaddr_o, exp_aw_q.pop_front());
         sl_aw_got = 1; sl_waddr = s_awaddr_o;
      end
      if (s_wvalid_o && s_wready_i) begin
         s_w_n++; w_hs_cyc = cyc;
         chk("w_expected", exp_w_q.size() > 0, 64'd1);
         if (exp_w_q.size() > 0) chk("wdata_wmask", {s_wmask_o, s_wdata_o}, exp_w_q.pop_front());
         sl_w_got = 1;
      end
      if (s_rvalid_i && s_rready_o) sl_r_pend = 0;
      if (s_bvalid_i && s_bready_o) begin
         sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 0;
      end
      if (sl_aw_got && sl_w_got && !sl_b_pend) begin
         sl_b_pend = 1; sl_b_wait = rand_mode ? $urandom_range(0, 2) : 0;
      end

      for (int i = 0; i < N; i++) begin
         if (m_arvalid_i[i] && m_arready_o[i]) ar_ok[i] = 1;
         if (m_awvalid_i[i] && m_awready_o[i]) aw_ok[i] = 1;
         if (m_wvalid_i[i] && m_wready_o[i])   w_ok[i] = 1;
         if (m_rvalid_o[i] && m_rready_i[i]) begin
            chk("r_owner", i, (!mdl_idle && mdl_rd) ? mdl_own : 99);
            chk("r_expected", act[i] && !m_wr[i] && ar_ok[i], 64'd1);
            chk("rdata_rresp", {m_rresp_o[i], m_rdata_o[i]}, {rd_resp(m_addr[i]), rd_val(m_addr[i])});
            act[i] = 0; finished[i]++; resp_cyc[i] = cyc; obs_rsp_q.push_back(i);
            mdl_rr = (mdl_own + 1) % N; mdl_idle = 1;
         end
         if (m_bvalid_o[i] && m_bready_i[i]) begin
            chk("b_owner", i, (!mdl_idle && !mdl_rd) ? mdl_own : 99);
            chk("b_expected", act[i] && m_wr[i] && aw_ok[i] && w_ok[i], 64'd1);
            chk("bresp", m_bresp_o[i], wr_resp(m_addr[i]));
            act[i] = 0; finished[i]++; resp_cyc[i] = cyc; obs_rsp_q.push_back(i);
            mdl_rr = (mdl_own + 1) % N; mdl_idle = 1;
         end
         if (act[i] && lead[i] > 0) lead[i]--;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      drive_inputs();
      #1;
      if (!reset) sample_update();
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         act[i] = 0; lead[i] = 0;
      end
      sl_r_pend = 0; sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 0; sl_r_block = 0; aw_stall = 0;
      s_ar_n = 0; s_aw_n = 0; s_w_n = 0;
      exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); obs_rsp_q.delete();
      mdl_idle = 1; mdl_rr = 0; mdl_own = 0; fresh = 0;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   function automatic bit any_active();
      bit a = 0;
      for (int i = 0; i < N; i++) a |= act[i];
      return a;
   endfunction

   task automatic run_until_done(input int limit, input string tag);
      int n = 0;
      while (any_active() && n < limit) begin
         step();
         n++;
      end
      chk({"drain_", tag}, n < limit, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int exp_order[6];
      exp_order = '{0, 1, 0, 1, 0, 1};
      reset = 1'b1;
      rand_mode = 0;
      for (int i = 0; i < N; i++) begin
         started[i] = 0; finished[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0;
      end
      drive_inputs();

      // reset values
      do_reset(2);
      step();
      chk("rst_state", state_o, 64'd0);
      chk("rst_gnt", gnt_idx_o, 64'd0);
      chk("rst_rr", rr_ptr_o, 64'd0);

      // single read from the IFU
      start_txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0);
      run_until_done(20, "single_read");
      chk("single_read_latency", resp_cyc[0], start_cyc[0] + 2);
      step();
      chk("single_read_idle", state_o, 64'd0);
      chk("single_read_rr", rr_ptr_o, 64'd1);

      // three back-to-back contention rounds
      do_reset(1);
      repeat (3) begin
         start_txn(0, 0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
         start_txn(1, 0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
         run_until_done(40, "contention");
      end
      chk("contention_count", obs_rsp_q.size(), 64'd6);
      for (int k = 0; k < 6 && k < obs_rsp_q.size(); k++)
         chk("contention_order", obs_rsp_q[k], exp_order[k]);

      // LSU write with W two cycles ahead of AW
      do_reset(1);
      start_txn(1, 1, 32'hA000_03F8, 32'hDEAD_BEEF, 4'hF, 2);
      run_until_done(30, "w_before_aw");
      chk("w_before_aw_aw_beats", s_aw_n, 64'd1);
      chk("w_before_aw_w_beats", s_w_n, 64'd1);
      chk("w_before_aw_done", finished[1], started[1]);

      // AW held off three cycles while W is accepted immediately
      do_reset(1);
      aw_stall = 3;
      start_txn(0, 1, 32'h0000_1230, 32'h0BAD_F00D, 4'h5, 0);
      run_until_done(30, "stagger");
      chk("stagger_aw_after_w", aw_hs_cyc - w_hs_cyc, 64'd3);
      chk("stagger_w_beats", s_w_n, 64'd1);
      chk("stagger_b_cycle", resp_cyc[0], aw_hs_cyc + 1);

      // IFU read and LSU write in the same cycle
      do_reset(1);
      start_txn(0, 0, 32'h0000_0044, 32'h0, 4'h0, 0);
      start_txn(1, 1, 32'h0000_0028, 32'h1357_9BDF, 4'hC, 0);
      run_until_done(30, "mixed");
      chk("mixed_count", obs_rsp_q.size(), 64'd2);
      if (obs_rsp_q.size() == 2) begin
         chk("mixed_first", obs_rsp_q[0], 64'd0);
         chk("mixed_second", obs_rsp_q[1], 64'd1);
      end
      chk("mixed_gap", resp_cyc[1] - resp_cyc[0], 64'd3);

      // random traffic with random slave and master stalls
      do_reset(1);
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!act[i] && $urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 1)
                  start_txn(i, 1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 2));
               else
                  start_txn(i, 0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
            end
         step();
      end
      run_until_done(500, "random");
      rand_mode = 0;
      for (int i = 0; i < N; i++) chk("random_all_done", finished[i], started[i]);
      chk("random_queues_empty", exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 64'd0);

      // reset while waiting for read data
      do_reset(1);
      sl_r_block = 1;
      start_txn(0, 0, 32'h0000_1000, 32'h0, 4'h0, 0);
      for (int n = 0; n < 10 && !sl_r_pend; n++) step();
      chk("abort_reached_rdata", sl_r_pend, 64'd1);
      step();
      chk("abort_in_rd_data", state_o, 64'd2);
      do_reset(1);
      step();
      chk("abort_outputs_zero", {m_arready_o, m_awready_o, m_wready_o, m_rvalid_o, m_bvalid_o,
                                 s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o}, 64'd0);
      chk("abort_state_idle", state_o, 64'd0);
      start_txn(1, 0, 32'h0000_2000, 32'h0, 4'h0, 0);
      run_until_done(20, "abort_recover");
      chk("abort_recover_owner", (obs_rsp_q.size() == 1) ? obs_rsp_q[0] : 99, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
